// File: rtl/basic_defs.sv
// Shared encodings for the basic-computer sequencer: bus selects, ALU ops, opcodes, T-steps.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package basic_defs;

    // Common-bus source select driven into the bus multiplexer.
    typedef enum logic [2:0] {
        BUS_NONE = 3'd0,
        BUS_AR   = 3'd1,
        BUS_PC   = 3'd2,
        BUS_DR   = 3'd3,
        BUS_AC   = 3'd4,
        BUS_IR   = 3'd5,
        BUS_TR   = 3'd6,
        BUS_MEM  = 3'd7
    } bus_sel_e;

    // ALU function applied when the accumulator loads.
    typedef enum logic [2:0] {
        ALU_PASS_DR = 3'd0,
        ALU_AND     = 3'd1,
        ALU_ADD     = 3'd2,
        ALU_COM     = 3'd3,
        ALU_SHR     = 3'd4,
        ALU_SHL     = 3'd5
    } alu_op_e;

    // Decoded opcode D = ir[14:12]; 7 covers register-reference and I/O.
    typedef enum logic [2:0] {
        OP_AND = 3'd0,
        OP_ADD = 3'd1,
        OP_LDA = 3'd2,
        OP_STA = 3'd3,
        OP_BUN = 3'd4,
        OP_BSA = 3'd5,
        OP_ISZ = 3'd6,
        OP_REG = 3'd7
    } opcode_e;

    // Timing steps of the sequence counter.
    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4,
        T5 = 3'd5,
        T6 = 3'd6
    } tstep_e;

    // Instruction field positions (fixed for a 16-bit word).
    localparam int IR_I_BIT  = 15;
    localparam int IR_OP_MSB = 14;
    localparam int IR_OP_LSB = 12;

    // Register-reference micro-operation bits.
    localparam int RR_CLA = 11;
    localparam int RR_CLE = 10;
    localparam int RR_CMA = 9;
    localparam int RR_CME = 8;
    localparam int RR_CIR = 7;
    localparam int RR_CIL = 6;
    localparam int RR_INC = 5;
    localparam int RR_SPA = 4;
    localparam int RR_SNA = 3;
    localparam int RR_SZA = 2;
    localparam int RR_SZE = 1;
    localparam int RR_HLT = 0;

    // All per-cycle control outputs bundled together.
    typedef struct packed {
        bus_sel_e bus_sel;
        alu_op_e  alu_op;
        logic     ar_ld;
        logic     ar_inr;
        logic     pc_ld;
        logic     pc_inr;
        logic     dr_ld;
        logic     dr_inr;
        logic     ac_ld;
        logic     ac_clr;
        logic     ac_inr;
        logic     ir_ld;
        logic     tr_ld;
        logic     e_clr;
        logic     e_cmp;
        logic     e_ld;
        logic     mem_rd;
        logic     mem_wr;
    } ctrl_t;

    // Skip decision for SPA/SNA/SZA/SZE; sk is ir[4:1] (SPA in bit 3).
    function automatic logic rr_skip(input logic [3:0] sk,
                                     input logic       ac_neg,
                                     input logic       ac_zero,
                                     input logic       e_in);
        return (sk[3] & ~ac_neg) |
               (sk[2] &  ac_neg) |
               (sk[1] &  ac_zero) |
               (sk[0] & ~e_in);
    endfunction

endpackage

// File: rtl/seq_counter.sv
// 3-bit timing-step counter (T0..T6) with clear, enable and synchronous active-low reset.
// Latency: count/clear visible one cycle after the enabled edge.
// Backpressure: en low holds the count; clear only acts on an enabled edge.
// Ports: clk, rst_n (sync, active low), en (advance), clr (return to 0), cnt (current step).
module seq_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    output logic [2:0] cnt
);

    logic [2:0] cnt_q;
    logic [2:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            // Wrap after T6 so the count can never leave the T0..T6 range.
            if (clr || (cnt_q >= 3'd6)) begin
                cnt_d = 3'd0;
            end else begin
                cnt_d = cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 3'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/basic_ctrl_seq.sv
// Instruction sequencer for the 16-bit basic computer: fetch, decode, memory- and register-reference execute.
// Latency: strobes are combinational on sc/D/I/halted plus live ir/ac/dr/e; state moves on enabled edges.
// Backpressure: en low freezes SC, D, I and halted and forces every strobe and bus_sel to 0.
// Ports: clk, rst_n (sync, active low), en; ir/ac/dr/e datapath inputs; bus_sel, register/E/memory
//        strobes and alu_op to the datapath; sc (current step) and halted status.
module basic_ctrl_seq
    import basic_defs::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] ir,
    input  logic [DATA_W-1:0] ac,
    input  logic [DATA_W-1:0] dr,
    input  logic              e,
    output logic [2:0]        bus_sel,
    output logic              ar_ld,
    output logic              ar_inr,
    output logic              pc_ld,
    output logic              pc_inr,
    output logic              dr_ld,
    output logic              dr_inr,
    output logic              ac_ld,
    output logic              ac_clr,
    output logic              ac_inr,
    output logic              ir_ld,
    output logic              tr_ld,
    output logic              e_clr,
    output logic              e_cmp,
    output logic              e_ld,
    output logic [2:0]        alu_op,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [2:0]        sc,
    output logic              halted
);

    opcode_e    d_q, d_d;
    logic       i_q, i_d;
    logic       halted_q, halted_d;
    logic [2:0] sc_cnt;
    logic       sc_clr;
    logic       sc_en;
    logic       active;
    tstep_e     step;
    ctrl_t      ctrl;

    logic       ac_neg;
    logic       ac_zero;
    logic       dr_zero;

    assign ac_neg  = ac[DATA_W-1];
    assign ac_zero = (ac == '0);
    assign dr_zero = (dr == '0);

    // Nothing is driven while stalled, in reset, or after HLT.
    assign active = en & rst_n & ~halted_q;
    // Halted parks SC at 0 (HLT's own T3 already cleared it).
    assign sc_en  = en & ~halted_q;
    assign step   = tstep_e'(sc_cnt);

    seq_counter u_seq_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (sc_en),
        .clr   (sc_clr),
        .cnt   (sc_cnt)
    );

    always_comb begin
        ctrl     = '0;
        sc_clr   = 1'b0;
        d_d      = d_q;
        i_d      = i_q;
        halted_d = halted_q;

        if (active) begin
            case (step)
                T0: begin
                    ctrl.bus_sel = BUS_PC;
                    ctrl.ar_ld   = 1'b1;
                end
                T1: begin
                    ctrl.bus_sel = BUS_MEM;
                    ctrl.mem_rd  = 1'b1;
                    ctrl.ir_ld   = 1'b1;
                    ctrl.pc_inr  = 1'b1;
                end
                T2: begin
                    ctrl.bus_sel = BUS_IR;
                    ctrl.ar_ld   = 1'b1;
                    d_d          = opcode_e'(ir[IR_OP_MSB:IR_OP_LSB]);
                    i_d          = ir[IR_I_BIT];
                end
                T3: begin
                    if (d_q == OP_REG) begin
                        // Register reference (I=0) decodes ir[11:0]; I/O (I=1) is a NOP.
                        if (!i_q) begin
                            ctrl.ac_clr = ir[RR_CLA];
                            ctrl.e_clr  = ir[RR_CLE];
                            ctrl.e_cmp  = ir[RR_CME];
                            ctrl.ac_inr = ir[RR_INC];
                            if (ir[RR_CMA]) begin
                                ctrl.alu_op = ALU_COM;
                                ctrl.ac_ld  = 1'b1;
                            end
                            if (ir[RR_CIR]) begin
                                ctrl.alu_op = ALU_SHR;
                                ctrl.ac_ld  = 1'b1;
                                ctrl.e_ld   = 1'b1;
                            end
                            if (ir[RR_CIL]) begin
                                ctrl.alu_op = ALU_SHL;
                                ctrl.ac_ld  = 1'b1;
                                ctrl.e_ld   = 1'b1;
                            end
                            ctrl.pc_inr = rr_skip(ir[RR_SPA:RR_SZE], ac_neg, ac_zero, e);
                            if (ir[RR_HLT]) begin
                                halted_d = 1'b1;
                            end
                        end
                        sc_clr = 1'b1;
                    end else if (i_q) begin
                        // Indirect: replace AR with the effective address from memory.
                        ctrl.bus_sel = BUS_MEM;
                        ctrl.mem_rd  = 1'b1;
                        ctrl.ar_ld   = 1'b1;
                    end
                end
                T4: begin
                    case (d_q)
                        OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
                            ctrl.bus_sel = BUS_MEM;
                            ctrl.mem_rd  = 1'b1;
                            ctrl.dr_ld   = 1'b1;
                        end
                        OP_STA: begin
                            ctrl.bus_sel = BUS_AC;
                            ctrl.mem_wr  = 1'b1;
                            sc_clr       = 1'b1;
                        end
                        OP_BUN: begin
                            ctrl.bus_sel = BUS_AR;
                            ctrl.pc_ld   = 1'b1;
                            sc_clr       = 1'b1;
                        end
                        OP_BSA: begin
                            // Store return address at M[AR], then step AR to the subroutine body.
                            ctrl.bus_sel = BUS_PC;
                            ctrl.mem_wr  = 1'b1;
                            ctrl.ar_inr  = 1'b1;
                        end
                        default: sc_clr = 1'b1;
                    endcase
                end
                T5: begin
                    case (d_q)
                        OP_AND: begin
                            ctrl.alu_op = ALU_AND;
                            ctrl.ac_ld  = 1'b1;
                            sc_clr      = 1'b1;
                        end
                        OP_ADD: begin
                            ctrl.alu_op = ALU_ADD;
                            ctrl.ac_ld  = 1'b1;
                            ctrl.e_ld   = 1'b1;
                            sc_clr      = 1'b1;
                        end
                        OP_LDA: begin
                            ctrl.alu_op = ALU_PASS_DR;
                            ctrl.ac_ld  = 1'b1;
                            sc_clr      = 1'b1;
                        end
                        OP_BSA: begin
                            ctrl.bus_sel = BUS_AR;
                            ctrl.pc_ld   = 1'b1;
                            sc_clr       = 1'b1;
                        end
                        OP_ISZ: begin
                            ctrl.dr_inr = 1'b1;
                        end
                        default: sc_clr = 1'b1;
                    endcase
                end
                T6: begin
                    // Only ISZ reaches T6: write back the incremented DR, skip on zero.
                    if (d_q == OP_ISZ) begin
                        ctrl.bus_sel = BUS_DR;
                        ctrl.mem_wr  = 1'b1;
                        ctrl.pc_inr  = dr_zero;
                    end
                    sc_clr = 1'b1;
                end
                default: sc_clr = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_q      <= OP_AND;
            i_q      <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            d_q      <= d_d;
            i_q      <= i_d;
            halted_q <= halted_d;
        end
    end

    assign bus_sel = ctrl.bus_sel;
    assign alu_op  = ctrl.alu_op;
    assign ar_ld   = ctrl.ar_ld;
    assign ar_inr  = ctrl.ar_inr;
    assign pc_ld   = ctrl.pc_ld;
    assign pc_inr  = ctrl.pc_inr;
    assign dr_ld   = ctrl.dr_ld;
    assign dr_inr  = ctrl.dr_inr;
    assign ac_ld   = ctrl.ac_ld;
    assign ac_clr  = ctrl.ac_clr;
    assign ac_inr  = ctrl.ac_inr;
    assign ir_ld   = ctrl.ir_ld;
    assign tr_ld   = ctrl.tr_ld;
    assign e_clr   = ctrl.e_clr;
    assign e_cmp   = ctrl.e_cmp;
    assign e_ld    = ctrl.e_ld;
    assign mem_rd  = ctrl.mem_rd;
    assign mem_wr  = ctrl.mem_wr;
    assign sc      = sc_cnt;
    assign halted  = halted_q;

endmodule

// File: tb/tb_basic_ctrl_seq.sv
// Testbench for basic_ctrl_seq: directed steps then randomized instructions against a trace model.
// Latency: n/a.
// Backpressure: en is toggled to exercise stalls.
module tb_basic_ctrl_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] ir, ac, dr;
    logic        e;
    logic [2:0]  bus_sel, alu_op, sc;
    logic        ar_ld, ar_inr, pc_ld, pc_inr, dr_ld, dr_inr, ac_ld, ac_clr, ac_inr;
    logic        ir_ld, tr_ld, e_clr, e_cmp, e_ld, mem_rd, mem_wr, halted;

    always #5 clk = ~clk;

    basic_ctrl_seq #(.DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .ir(ir), .ac(ac), .dr(dr), .e(e),
        .bus_sel(bus_sel), .ar_ld(ar_ld), .ar_inr(ar_inr), .pc_ld(pc_ld), .pc_inr(pc_inr),
        .dr_ld(dr_ld), .dr_inr(dr_inr), .ac_ld(ac_ld), .ac_clr(ac_clr), .ac_inr(ac_inr),
        .ir_ld(ir_ld), .tr_ld(tr_ld), .e_clr(e_clr), .e_cmp(e_cmp), .e_ld(e_ld),
        .alu_op(alu_op), .mem_rd(mem_rd), .mem_wr(mem_wr), .sc(sc), .halted(halted)
    );

    typedef struct packed {
        logic [2:0] bus;
        logic ar_ld, ar_inr, pc_ld, pc_inr, dr_ld, dr_inr, ac_ld, ac_clr, ac_inr;
        logic ir_ld, tr_ld, e_clr, e_cmp, e_ld;
        logic [2:0] alu;
        logic mem_rd, mem_wr;
    } vec_t;

    typedef struct {
        vec_t       v;
        logic [2:0] sc;
        logic       hlt;
    } step_t;

    step_t trace[$];
    bit    m_halted;
    int    n_vec, n_err;

    function automatic vec_t obs();
        vec_t o;
        o.bus = bus_sel;   o.ar_ld = ar_ld;   o.ar_inr = ar_inr; o.pc_ld = pc_ld;
        o.pc_inr = pc_inr; o.dr_ld = dr_ld;   o.dr_inr = dr_inr; o.ac_ld = ac_ld;
        o.ac_clr = ac_clr; o.ac_inr = ac_inr; o.ir_ld = ir_ld;   o.tr_ld = tr_ld;
        o.e_clr = e_clr;   o.e_cmp = e_cmp;   o.e_ld = e_ld;     o.alu = alu_op;
        o.mem_rd = mem_rd; o.mem_wr = mem_wr;
        return o;
    endfunction

    function automatic void push(input vec_t v, input logic h);
        step_t s;
        s.v   = v;
        s.sc  = 3'(trace.size());
        s.hlt = h;
        trace.push_back(s);
    endfunction

    // Micro-operation list of one whole instruction, one entry per timing step.
    function automatic void build(input logic [15:0] iw, input logic [15:0] ac_v,
                                  input logic [15:0] dr_v, input logic e_v);
        vec_t v;
        int   opc;
        logic ind;
        opc = int'(iw[14:12]);
        ind = iw[15];
        trace.delete();
        v = '0; v.bus = 3'd2; v.ar_ld = 1'b1; push(v, 1'b0);
        v = '0; v.bus = 3'd7; v.mem_rd = 1'b1; v.ir_ld = 1'b1; v.pc_inr = 1'b1; push(v, 1'b0);
        v = '0; v.bus = 3'd5; v.ar_ld = 1'b1; push(v, 1'b0);
        if (opc == 7) begin
            v = '0;
            if (!ind) begin
                v.ac_clr = iw[11];
                v.e_clr  = iw[10];
                if (iw[9]) begin v.alu = 3'd3; v.ac_ld = 1'b1; end
                v.e_cmp  = iw[8];
                if (iw[7]) begin v.alu = 3'd4; v.ac_ld = 1'b1; v.e_ld = 1'b1; end
                if (iw[6]) begin v.alu = 3'd5; v.ac_ld = 1'b1; v.e_ld = 1'b1; end
                v.ac_inr = iw[5];
                v.pc_inr = (iw[4] && ac_v < 16'h8000) || (iw[3] && ac_v >= 16'h8000) ||
                           (iw[2] && ac_v == 16'd0) || (iw[1] && e_v == 1'b0);
                push(v, iw[0]);
            end else begin
                push(v, 1'b0);
            end
            return;
        end
        v = '0;
        if (ind) begin v.bus = 3'd7; v.mem_rd = 1'b1; v.ar_ld = 1'b1; end
        push(v, 1'b0);
        v = '0;
        case (opc)
            0, 1, 2, 6: begin v.bus = 3'd7; v.mem_rd = 1'b1; v.dr_ld = 1'b1; end
            3: begin v.bus = 3'd4; v.mem_wr = 1'b1; push(v, 1'b0); return; end
            4: begin v.bus = 3'd1; v.pc_ld = 1'b1; push(v, 1'b0); return; end
            default: begin v.bus = 3'd2; v.mem_wr = 1'b1; v.ar_inr = 1'b1; end
        endcase
        push(v, 1'b0);
        v = '0;
        case (opc)
            0: begin v.alu = 3'd1; v.ac_ld = 1'b1; end
            1: begin v.alu = 3'd2; v.ac_ld = 1'b1; v.e_ld = 1'b1; end
            2: begin v.alu = 3'd0; v.ac_ld = 1'b1; end
            5: begin v.bus = 3'd1; v.pc_ld = 1'b1; end
            default: v.dr_inr = 1'b1;
        endcase
        push(v, 1'b0);
        if (opc == 6) begin
            v = '0; v.bus = 3'd3; v.mem_wr = 1'b1; v.pc_inr = (dr_v == 16'd0);
            push(v, 1'b0);
        end
    endfunction

    task automatic check(input string tag);
        vec_t       exp_v, o_v;
        logic [2:0] exp_sc;
        exp_v  = '0;
        exp_sc = 3'd0;
        if (!m_halted && trace.size() > 0) begin
            exp_sc = trace[0].sc;
            if (en) exp_v = trace[0].v;
        end
        o_v = obs();
        // alu_op is only meaningful while AC or E is loading.
        if (!exp_v.ac_ld && !exp_v.e_ld) begin
            o_v.alu   = '0;
            exp_v.alu = '0;
        end
        n_vec++;
        assert (o_v === exp_v) else begin
            n_err++;
            $error("FAIL %s strobes: observed %h expected %h", tag, o_v, exp_v);
        end
        n_vec++;
        assert (sc === exp_sc) else begin
            n_err++;
            $error("FAIL %s sc: observed %0d expected %0d", tag, sc, exp_sc);
        end
        n_vec++;
        assert (halted === m_halted) else begin
            n_err++;
            $error("FAIL %s halted: observed %b expected %b", tag, halted, m_halted);
        end
    endtask

    // Entered one time unit after a rising edge; samples two units later.
    task automatic tick(input string tag);
        step_t s;
        #2;
        check(tag);
        @(posedge clk);
        #1;
        if (en && !m_halted && trace.size() > 0) begin
            s = trace.pop_front();
            if (s.hlt) m_halted = 1'b1;
        end
    endtask

    task automatic run_instr(input string tag, input logic [15:0] iw, input logic [15:0] ac_v,
                             input logic [15:0] dr_v, input logic e_v,
                             input int stall_sc, input int stall_n, input bit rand_en,
                             input int stop_sc);
        int guard;
        guard = 0;
        ir = iw; ac = ac_v; dr = dr_v; e = e_v;
        build(iw, ac_v, dr_v, e_v);
        while (trace.size() > 0 && !m_halted) begin
            if (stop_sc >= 0 && int'(trace[0].sc) == stop_sc) break;
            guard++;
            if (guard > 200) begin
                n_err++;
                $display("FAIL %s: instruction not finished within cycle budget", tag);
                break;
            end
            if (stall_n > 0 && int'(trace[0].sc) == stall_sc) begin
                en = 1'b0;
                stall_n--;
            end else if (rand_en) begin
                en = ($urandom_range(0, 3) != 0);
            end else begin
                en = 1'b1;
            end
            tick(tag);
        end
        en = 1'b1;
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        en    = 1'b1;
        #2;
        n_vec++;
        assert (obs() === vec_t'(0)) else begin
            n_err++;
            $error("FAIL %s strobes in reset: observed %h expected 0", tag, obs());
        end
        @(posedge clk);
        #1;
        trace.delete();
        m_halted = 1'b0;
        n_vec++;
        assert (sc === 3'd0 && halted === 1'b0) else begin
            n_err++;
            $error("FAIL %s reset edge: observed sc=%0d halted=%b expected sc=0 halted=0", tag, sc, halted);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] iw, av, dv;
        int          opc;
        n_vec = 0; n_err = 0; m_halted = 1'b0;
        rst_n = 1'b0; en = 1'b1; ir = '0; ac = '0; dr = '0; e = 1'b0;
        @(posedge clk);
        #1;
        do_reset("por");

        run_instr("cla",       16'h7800, 16'h1234, 16'h0000, 1'b0, -1, 0, 1'b0, -1);
        run_instr("add_dir",   16'h1005, 16'h0003, 16'h0004, 1'b1, -1, 0, 1'b0, -1);
        run_instr("isz_dr0",   16'hE006, 16'h0000, 16'h0000, 1'b0, -1, 0, 1'b0, -1);
        run_instr("isz_dr1",   16'hE006, 16'h0000, 16'h0001, 1'b0, -1, 0, 1'b0, -1);
        run_instr("spa_neg",   16'h7010, 16'h8000, 16'h0000, 1'b0, -1, 0, 1'b0, -1);
        run_instr("spa_pos",   16'h7010, 16'h0001, 16'h0000, 1'b0, -1, 0, 1'b0, -1);
        run_instr("sta_stall", 16'h3010, 16'h00AA, 16'h0000, 1'b0, 4, 3, 1'b0, -1);
        run_instr("bsa_rst",   16'h5020, 16'h0000, 16'h0000, 1'b0, -1, 0, 1'b0, 5);
        do_reset("bsa_rst");
        run_instr("after_rst", 16'h4030, 16'h0000, 16'h0000, 1'b0, -1, 0, 1'b0, -1);

        // Randomized instruction stream with random stalls.
        for (int k = 0; k < 150; k++) begin
            opc = $urandom_range(0, 7);
            iw  = 16'($urandom);
            iw[14:12] = 3'(opc);
            if (opc == 7 && !iw[15]) iw[11:0] = 12'h001 << $urandom_range(1, 11);
            case ($urandom_range(0, 2))
                0: av = 16'h0000;
                1: av = 16'h8000 | 16'($urandom);
                default: av = 16'($urandom);
            endcase
            dv = ($urandom_range(0, 1) != 0) ? 16'h0000 : 16'($urandom);
            run_instr("rand", iw, av, dv, 1'($urandom_range(0, 1)), -1, 0, 1'b1, -1);
        end

        run_instr("hlt", 16'h7001, 16'h0000, 16'h0000, 1'b0, -1, 0, 1'b0, -1);
        for (int k = 0; k < 20; k++) begin
            en = ($urandom_range(0, 3) != 0);
            tick("halted_hold");
        end
        en = 1'b1;
        do_reset("hlt_rst");
        run_instr("post_hlt", 16'h7020, 16'h0000, 16'h0000, 1'b0, -1, 0, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
